sobel_frame_ctrl: RTL

- Frame-level sequencer that drives the grayscale→padding→sobel pipeline system for one image per start command.
- Reads RGB pixels from a synchronous source memory and pushes them into the pipeline input FIFO.
- Drains the sobel output FIFO into a destination memory.
- Tracks pixel counts, signals frame completion, counts frames and flags stalls with a watchdog.

---
 rtl/sobel_frame_ctrl_if.sv | 39 +++
 rtl/sobel_frame_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl_if.sv
// Memory / FIFO bus between the frame sequencer and its surroundings.
//   master : sequencer side (drives read/write strobes, addresses, FIFO data)
//   slave  : memory/pipeline side
// Signals: src_rd_en/src_addr/src_rdata     synchronous source memory
//          fifo_in_wr_en/fifo_in_din/full   pipeline input FIFO
//          fifo_out_rd_en/dout/empty        pipeline output FIFO (FWFT)
//          dst_wr_en/dst_addr/dst_wdata     destination memory
interface sobel_frame_ctrl_if #(
  parameter int unsigned ADDR_WIDTH   = 19,
  parameter int unsigned RGB_DWIDTH   = 24,
  parameter int unsigned SOBEL_DWIDTH = 8
);
  logic                    src_rd_en;
  logic [ADDR_WIDTH-1:0]   src_addr;
  logic [RGB_DWIDTH-1:0]   src_rdata;
  logic                    fifo_in_wr_en;
  logic [RGB_DWIDTH-1:0]   fifo_in_din;
  logic                    fifo_in_full;
  logic                    fifo_out_rd_en;
  logic [SOBEL_DWIDTH-1:0] fifo_out_dout;
  logic                    fifo_out_empty;
  logic                    dst_wr_en;
  logic [ADDR_WIDTH-1:0]   dst_addr;
  logic [SOBEL_DWIDTH-1:0] dst_wdata;

  modport master (
    output src_rd_en, src_addr, input src_rdata,
    output fifo_in_wr_en, fifo_in_din, input fifo_in_full,
    output fifo_out_rd_en, input fifo_out_dout, fifo_out_empty,
    output dst_wr_en, dst_addr, dst_wdata
  );

  modport slave (
    input src_rd_en, src_addr, output src_rdata,
    input fifo_in_wr_en, fifo_in_din, output fifo_in_full,
    input fifo_out_rd_en, output fifo_out_dout, fifo_out_empty,
    input dst_wr_en, dst_addr, dst_wdata
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the grayscale->padding->sobel pipeline.
// One start in IDLE runs one frame: source pixels are read and pushed into the
// pipeline input FIFO, sobel results are drained into destination memory.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   start                 begin a frame (IDLE only)
//   src_base, dst_base    frame base addresses, latched on accepted start
//   busy                  high while the frame runs
//   done                  one-cycle completion pulse
//   error                 sticky watchdog flag (cleared only by reset)
//   frame_count           completed frames, wrapping
//   bus                   memory / FIFO bus (master side)
module sobel_frame_ctrl #(
  parameter int unsigned IMG_WIDTH      = 720,
  parameter int unsigned IMG_HEIGHT     = 540,
  parameter int unsigned RGB_DWIDTH     = 24,
  parameter int unsigned SOBEL_DWIDTH   = 8,
  parameter int unsigned ADDR_WIDTH     = 19,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           frame_count,
  sobel_frame_ctrl_if.master    bus
);

  localparam int unsigned TOTAL_I = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_WIDTH:0] TOTAL = (ADDR_WIDTH+1)'(TOTAL_I);
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH:0]     rd_cnt, in_cnt, out_cnt;
  logic [ADDR_WIDTH-1:0]   src_base_r, dst_base_r;
  logic                    rd_pend;
  logic                    hold_vld;
  logic [RGB_DWIDTH-1:0]   hold_data;
  logic [WD_W-1:0]         wd_cnt;

  logic rd_issue, hold_wr, ret_wr, ret_hold, drain, progress;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Read data arrives one cycle after the strobe; if the FIFO is full at that
  // moment it parks in the hold register. Reads are withheld while the hold
  // register is occupied, so a return and a hold flush never coincide.
  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    hold_wr   = 1'b0;
    ret_wr    = 1'b0;
    ret_hold  = 1'b0;
    drain     = 1'b0;
    progress  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        hold_wr  = hold_vld && !bus.fifo_in_full;
        ret_wr   = rd_pend && !bus.fifo_in_full;
        ret_hold = rd_pend && bus.fifo_in_full;
        rd_issue = (rd_cnt < TOTAL) && !bus.fifo_in_full && !hold_vld && !ret_hold;
        drain    = !bus.fifo_out_empty && (out_cnt < TOTAL);
        progress = rd_issue || hold_wr || ret_wr || drain;
        if (drain && (out_cnt == TOTAL - 1'b1)) state_nxt = DONE;
        else if (!progress && (wd_cnt == WD_LAST)) state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = ERR;
    endcase
  end

  assign busy               = (state == RUN);
  assign done               = (state == DONE);
  assign bus.src_rd_en      = rd_issue;
  assign bus.src_addr       = rd_issue ? src_base_r + rd_cnt[ADDR_WIDTH-1:0] : '0;
  assign bus.fifo_in_wr_en  = hold_wr || ret_wr;
  assign bus.fifo_in_din    = hold_wr ? hold_data : (ret_wr ? bus.src_rdata : '0);
  assign bus.fifo_out_rd_en = drain;
  assign bus.dst_wr_en      = drain;
  assign bus.dst_addr       = drain ? dst_base_r + out_cnt[ADDR_WIDTH-1:0] : '0;
  assign bus.dst_wdata      = drain ? bus.fifo_out_dout : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cnt      <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      src_base_r  <= '0;
      dst_base_r  <= '0;
      rd_pend     <= 1'b0;
      hold_vld    <= 1'b0;
      hold_data   <= '0;
      wd_cnt      <= '0;
      error       <= 1'b0;
      frame_count <= '0;
    end else begin
      rd_pend <= rd_issue;
      if (state_nxt == ERR) error <= 1'b1;
      case (state)
        IDLE: if (start) begin
          rd_cnt     <= '0;
          in_cnt     <= '0;
          out_cnt    <= '0;
          wd_cnt     <= '0;
          hold_vld   <= 1'b0;
          src_base_r <= src_base;
          dst_base_r <= dst_base;
        end
        RUN: begin
          if (rd_issue)          rd_cnt  <= rd_cnt + 1'b1;
          if (hold_wr || ret_wr) in_cnt  <= in_cnt + 1'b1;
          if (drain)             out_cnt <= out_cnt + 1'b1;
          if (hold_wr) begin
            hold_vld <= 1'b0;
          end else if (ret_hold) begin
            hold_vld  <= 1'b1;
            hold_data <= bus.src_rdata;
          end
          wd_cnt <= progress ? '0 : wd_cnt + 1'b1;
        end
        DONE: frame_count <= frame_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
